sprite_compositor: RTL and testbench

//   Parametrised, pipelined VGA layer compositor; generalises the combinational pixel mux to NSPR sprites.

---
 rtl/sprite_compositor.sv | 181 ++++++++++++++++++
 tb/tb_sprite_compositor.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_compositor.sv
// Two-stage VGA layer compositor: NSPR colour-keyed sprites over a dot grid and a
// background band, with sprite state shadowed per frame and sprite-0 collision flags.

module sprite_compositor_hit #(
  parameter int PW = 10
) (
  input  logic [PW-1:0] h_i,
  input  logic [PW-1:0] v_i,
  input  logic [PW-1:0] x_i,
  input  logic [PW-1:0] y_i,
  input  logic [PW-1:0] w_i,
  input  logic [PW-1:0] hgt_i,
  input  logic          en_i,
  output logic          hit_o
);
  // Right/bottom edges carry an extra bit so x+w never wraps.
  logic [PW:0] xe, ye;
  assign xe    = {1'b0, x_i} + {1'b0, w_i};
  assign ye    = {1'b0, y_i} + {1'b0, hgt_i};
  assign hit_o = en_i && (h_i >= x_i) && ({1'b0, h_i} < xe)
                      && (v_i >= y_i) && ({1'b0, v_i} < ye);
endmodule

module sprite_compositor #(
  parameter int            NSPR  = 4,
  parameter int            CW    = 12,
  parameter int            PW    = 10,
  parameter logic [CW-1:0] TKEY  = '0,
  parameter int            GX0   = 49,
  parameter int            GY0   = 191,
  parameter int            TILE  = 30,
  parameter int            GCOLS = 18,
  parameter int            GROWS = 5,
  parameter int            BG_V0 = 30,
  parameter int            BG_V1 = 370,
  localparam int           DOTS  = GCOLS * GROWS,
  localparam int           CN    = (NSPR > 1) ? NSPR - 1 : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid,
  input  logic [PW-1:0]        h_cnt,
  input  logic [PW-1:0]        v_cnt,
  input  logic                 frame_start,
  input  logic [NSPR*PW-1:0]   spr_x,
  input  logic [NSPR*PW-1:0]   spr_y,
  input  logic [NSPR*PW-1:0]   spr_w,
  input  logic [NSPR*PW-1:0]   spr_h,
  input  logic [NSPR-1:0]      spr_en,
  input  logic [NSPR*CW-1:0]   spr_pixel,
  input  logic [DOTS-1:0]      dot_map,
  input  logic [DOTS-1:0]      big_map,
  input  logic [CW-1:0]        dot_pixel,
  input  logic [CW-1:0]        big_pixel,
  input  logic [CW-1:0]        bg_pixel,
  output logic [CW/3-1:0]      vgaRed,
  output logic [CW/3-1:0]      vgaGreen,
  output logic [CW/3-1:0]      vgaBlue,
  output logic [CN-1:0]        collide,
  output logic [7:0]           frame_cnt
);
  localparam int GX1 = GX0 + GCOLS * TILE;
  localparam int GY1 = GY0 + GROWS * TILE;
  localparam int IW  = $clog2(DOTS + 1);

  typedef logic [NSPR-1:0][PW-1:0] coord_t;

  coord_t          x_q, y_q, w_q, h_q;
  coord_t          x_e, y_e, w_e, h_e;
  logic [NSPR-1:0] en_q, en_e;

  // The frame_start pixel must already see the new frame's sprite state.
  assign x_e  = frame_start ? coord_t'(spr_x) : x_q;
  assign y_e  = frame_start ? coord_t'(spr_y) : y_q;
  assign w_e  = frame_start ? coord_t'(spr_w) : w_q;
  assign h_e  = frame_start ? coord_t'(spr_h) : h_q;
  assign en_e = frame_start ? spr_en : en_q;

  logic [NSPR-1:0] hit_d, hit_q, opq;
  logic            s1_vld_q, dot_q, big_q, band_q;
  logic            dot_d, big_d, band_d, in_cell;
  logic [PW-1:0]   hoff, voff;
  logic [IW-1:0]   col, row, idx;
  logic [CW-1:0]   rgb_d, rgb_q;
  logic [CN-1:0]   cur, pend_q, collide_q;
  logic [7:0]      fc_q;

  for (genvar k = 0; k < NSPR; k++) begin : g_spr
    sprite_compositor_hit #(.PW(PW)) u_hit (
      .h_i  (h_cnt),
      .v_i  (v_cnt),
      .x_i  (x_e[k]),
      .y_i  (y_e[k]),
      .w_i  (w_e[k]),
      .hgt_i(h_e[k]),
      .en_i (en_e[k]),
      .hit_o(hit_d[k])
    );
    assign opq[k] = hit_q[k] && (spr_pixel[k*CW +: CW] != TKEY);
  end

  always_comb begin
    hoff    = h_cnt - PW'(GX0);
    voff    = v_cnt - PW'(GY0);
    col     = IW'(hoff / PW'(TILE));
    row     = IW'(voff / PW'(TILE));
    idx     = col + row * IW'(GCOLS);
    in_cell = (int'(h_cnt) >= GX0 + 6) && (int'(h_cnt) < GX1) &&
              (int'(v_cnt) >= GY0)     && (int'(v_cnt) < GY1);
    dot_d   = 1'b0;
    big_d   = 1'b0;
    if (in_cell && (idx < IW'(DOTS))) begin
      dot_d = dot_map[idx];
      big_d = big_map[idx];
    end
    band_d  = (int'(v_cnt) >= BG_V0) && (int'(v_cnt) < BG_V1);
  end

  // Lowest index wins: walk from the bottom sprite up so higher priority overwrites.
  always_comb begin
    rgb_d = '0;
    if (dot_q)       rgb_d = big_q ? big_pixel : dot_pixel;
    else if (band_q) rgb_d = bg_pixel;
    for (int k = NSPR - 1; k >= 0; k--)
      if (opq[k]) rgb_d = spr_pixel[k*CW +: CW];
    if (!s1_vld_q) rgb_d = '0;
  end

  if (NSPR > 1) begin : g_col
    for (genvar k = 1; k < NSPR; k++) begin : g_pair
      assign cur[k-1] = s1_vld_q && opq[0] && opq[k];
    end
  end else begin : g_nocol
    assign cur = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q       <= '0;
      y_q       <= '0;
      w_q       <= '0;
      h_q       <= '0;
      en_q      <= '0;
      s1_vld_q  <= 1'b0;
      hit_q     <= '0;
      dot_q     <= 1'b0;
      big_q     <= 1'b0;
      band_q    <= 1'b0;
      rgb_q     <= '0;
      pend_q    <= '0;
      collide_q <= '0;
      fc_q      <= '0;
    end else begin
      s1_vld_q <= valid;
      hit_q    <= hit_d;
      dot_q    <= dot_d;
      big_q    <= big_d;
      band_q   <= band_d;
      rgb_q    <= rgb_d;
      if (frame_start) begin
        x_q       <= x_e;
        y_q       <= y_e;
        w_q       <= w_e;
        h_q       <= h_e;
        en_q      <= en_e;
        // The S2 pixel in this cycle still belongs to the frame that is ending.
        collide_q <= pend_q | cur;
        pend_q    <= '0;
        fc_q      <= fc_q + 8'd1;
      end else begin
        pend_q    <= pend_q | cur;
      end
    end
  end

  assign vgaRed    = rgb_q[CW-1 -: CW/3];
  assign vgaGreen  = rgb_q[2*(CW/3)-1 -: CW/3];
  assign vgaBlue   = rgb_q[CW/3-1:0];
  assign collide   = collide_q;
  assign frame_cnt = fc_q;
endmodule

// File: tb/tb_sprite_compositor.sv
// Bench for sprite_compositor: directed scenarios plus a randomized stream checked
// against a per-pixel layer model built from the compositing rules.

module tb_sprite_compositor;
  localparam int NSPR = 4, CW = 12, PW = 10, DOTS = 90;
  localparam logic [11:0] TKEY = 12'h000;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                valid, frame_start;
  logic [PW-1:0]       h_cnt, v_cnt;
  logic [NSPR*PW-1:0]  spr_x, spr_y, spr_w, spr_h;
  logic [NSPR-1:0]     spr_en;
  logic [NSPR*CW-1:0]  spr_pixel;
  logic [DOTS-1:0]     dot_map, big_map;
  logic [CW-1:0]       dot_pixel, big_pixel, bg_pixel;
  logic [3:0]          vgaRed, vgaGreen, vgaBlue;
  logic [2:0]          collide;
  logic [7:0]          frame_cnt;
  logic [11:0]         rgb;

  assign rgb = {vgaRed, vgaGreen, vgaBlue};
  always #5 clk = ~clk;

  sprite_compositor dut (
    .clk(clk), .rst_n(rst_n), .valid(valid), .h_cnt(h_cnt), .v_cnt(v_cnt),
    .frame_start(frame_start), .spr_x(spr_x), .spr_y(spr_y), .spr_w(spr_w),
    .spr_h(spr_h), .spr_en(spr_en), .spr_pixel(spr_pixel), .dot_map(dot_map),
    .big_map(big_map), .dot_pixel(dot_pixel), .big_pixel(big_pixel),
    .bg_pixel(bg_pixel), .vgaRed(vgaRed), .vgaGreen(vgaGreen), .vgaBlue(vgaBlue),
    .collide(collide), .frame_cnt(frame_cnt)
  );

  int checks = 0, failures = 0;

  // Stimulus state: sprite registers as the CPU would write them, ROM data per pixel.
  logic [PW-1:0]   in_x[NSPR], in_y[NSPR], in_w[NSPR], in_h[NSPR];
  logic [NSPR-1:0] in_en;
  logic [11:0]     rom_spr[NSPR];
  logic [11:0]     rom_dot, rom_big, rom_bg;

  // Reference model state.
  int              sx[NSPR], sy[NSPR], sw[NSPR], sh[NSPR];
  bit [NSPR-1:0]   sen;
  int              p_h, p_v;
  bit              p_vld;
  bit [NSPR-1:0]   p_in;
  logic [DOTS-1:0] p_dmap, p_bmap;
  bit [2:0]        pend_m, exp_col;
  int              exp_fc;
  logic [11:0]     exp_rgb;

  task automatic model_reset;
    for (int k = 0; k < NSPR; k++) begin sx[k] = 0; sy[k] = 0; sw[k] = 0; sh[k] = 0; end
    sen = '0; p_vld = 1'b0; p_in = '0; p_h = 0; p_v = 0;
    p_dmap = '0; p_bmap = '0; pend_m = '0; exp_col = '0; exp_fc = 0; exp_rgb = '0;
  endtask

  task automatic do_reset;
    valid = 1'b0; frame_start = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_spr(input int k, input int x, input int y, input int w, input int h,
                         input bit en);
    in_x[k] = 10'(x); in_y[k] = 10'(y); in_w[k] = 10'(w); in_h[k] = 10'(h); in_en[k] = en;
  endtask

  task automatic all_off;
    for (int k = 0; k < NSPR; k++) set_spr(k, 0, 0, 0, 0, 1'b0);
    for (int k = 0; k < NSPR; k++) rom_spr[k] = TKEY;
  endtask

  // One pixel clock: at the falling edge present the ROM data belonging to the previous
  // pixel and the new pixel; returns just after the rising edge that registers them.
  task automatic tick(input int h, input int v, input bit vl, input bit fs);
    logic [11:0]   c;
    bit [NSPR-1:0] op;
    int            idx;
    @(negedge clk);
    for (int k = 0; k < NSPR; k++) spr_pixel[k*CW +: CW] = rom_spr[k];
    dot_pixel = rom_dot; big_pixel = rom_big; bg_pixel = rom_bg;
    c = '0; op = '0;
    if (p_vld) begin
      if (p_v >= 30 && p_v < 370) c = rom_bg;
      if (p_h >= 55 && p_h < 49 + 18*30 && p_v >= 191 && p_v < 191 + 5*30) begin
        idx = (p_h - 49) / 30 + ((p_v - 191) / 30) * 18;
        if (p_dmap[idx]) c = p_bmap[idx] ? rom_big : rom_dot;
      end
      for (int k = NSPR - 1; k >= 0; k--) begin
        op[k] = p_in[k] && (rom_spr[k] != TKEY);
        if (op[k]) c = rom_spr[k];
      end
      for (int k = 1; k < NSPR; k++) if (op[0] && op[k]) pend_m[k-1] = 1'b1;
    end
    exp_rgb = c;
    h_cnt = 10'(h); v_cnt = 10'(v); valid = vl; frame_start = fs;
    for (int k = 0; k < NSPR; k++) begin
      spr_x[k*PW +: PW] = in_x[k]; spr_y[k*PW +: PW] = in_y[k];
      spr_w[k*PW +: PW] = in_w[k]; spr_h[k*PW +: PW] = in_h[k];
    end
    spr_en = in_en;
    if (fs) begin
      for (int k = 0; k < NSPR; k++) begin
        sx[k] = int'(in_x[k]); sy[k] = int'(in_y[k]); sw[k] = int'(in_w[k]); sh[k] = int'(in_h[k]);
      end
      sen = in_en;
      exp_col = pend_m; pend_m = '0;
      exp_fc = (exp_fc + 1) % 256;
    end
    for (int k = 0; k < NSPR; k++)
      p_in[k] = sen[k] && h >= sx[k] && h < sx[k] + sw[k] && v >= sy[k] && v < sy[k] + sh[k];
    p_h = h; p_v = v; p_vld = vl; p_dmap = dot_map; p_bmap = big_map;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    valid = 1'b1; frame_start = 1'b1; h_cnt = 10'd100; v_cnt = 10'd50;
    spr_x = '0; spr_y = '0; spr_w = '1; spr_h = '1; spr_en = '1; spr_pixel = '1;
    dot_map = '0; big_map = '0; dot_pixel = '1; big_pixel = '1; bg_pixel = '1;
    all_off(); rom_dot = '0; rom_big = '0; rom_bg = '0;
    rst_n = 1'b0; model_reset();
    repeat (3) @(posedge clk); #1;
    checks++; if (rgb !== 12'h000) begin failures++; $display("FAIL reset_rgb: got %h want 000", rgb); end
    checks++; if (collide !== 3'b000) begin failures++; $display("FAIL reset_collide: got %b want 000", collide); end
    checks++; if (frame_cnt !== 8'd0) begin failures++; $display("FAIL reset_fcnt: got %0d want 0", frame_cnt); end
    valid = 1'b0; frame_start = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_basic;
    all_off(); set_spr(0, 100, 50, 30, 29, 1'b1); rom_bg = 12'h123;
    tick(0, 0, 1, 1);
    checks++; if (frame_cnt !== 8'd1) begin failures++; $display("FAIL basic_fcnt: got %0d want 1", frame_cnt); end
    tick(100, 50, 1, 0);
    checks++; if (rgb !== 12'h000) begin failures++; $display("FAIL basic_latency: got %h want 000", rgb); end
    rom_spr[0] = 12'hF00;
    tick(130, 50, 1, 0);
    checks++; if ({vgaRed, vgaGreen, vgaBlue} !== {4'hF, 4'h0, 4'h0})
      begin failures++; $display("FAIL basic_sprite: got %h want F00", rgb); end
    tick(0, 0, 1, 0);
    checks++; if (rgb !== 12'h123) begin failures++; $display("FAIL basic_right_edge: got %h want 123", rgb); end
  endtask

  task automatic test_priority;
    all_off(); set_spr(0, 190, 90, 20, 20, 1'b1); set_spr(1, 195, 95, 20, 20, 1'b1);
    tick(0, 0, 1, 1);
    tick(200, 100, 1, 0);
    rom_spr[0] = TKEY; rom_spr[1] = 12'h0F0;
    tick(200, 100, 1, 0);
    checks++; if (rgb !== 12'h0F0) begin failures++; $display("FAIL prio_key: got %h want 0F0", rgb); end
    rom_spr[0] = 12'h00F;
    tick(0, 0, 0, 0);
    checks++; if (rgb !== 12'h00F) begin failures++; $display("FAIL prio_top: got %h want 00F", rgb); end
  endtask

  task automatic test_dots;
    all_off(); rom_big = 12'hABC; rom_dot = 12'hDEF; rom_bg = 12'h111;
    dot_map = '0; big_map = '0; dot_map[38] = 1'b1; big_map[38] = 1'b1;
    tick(0, 0, 1, 1);
    tick(110, 251, 1, 0);
    big_map[38] = 1'b0;
    tick(110, 251, 1, 0);
    checks++; if (rgb !== 12'hABC) begin failures++; $display("FAIL dot_big: got %h want ABC", rgb); end
    dot_map[38] = 1'b0;
    tick(110, 251, 1, 0);
    checks++; if (rgb !== 12'hDEF) begin failures++; $display("FAIL dot_small: got %h want DEF", rgb); end
    dot_map[0] = 1'b1;
    tick(54, 191, 1, 0);
    checks++; if (rgb !== 12'h111) begin failures++; $display("FAIL dot_none: got %h want 111", rgb); end
    tick(55, 191, 1, 0);
    checks++; if (rgb !== 12'h111) begin failures++; $display("FAIL dot_left_margin: got %h want 111", rgb); end
    tick(0, 0, 0, 0);
    checks++; if (rgb !== 12'hDEF) begin failures++; $display("FAIL dot_first_col: got %h want DEF", rgb); end
    dot_map = '0;
  endtask

  task automatic test_shadow;
    all_off(); set_spr(0, 100, 50, 30, 29, 1'b1); rom_spr[0] = 12'hF00; rom_bg = 12'h123;
    tick(0, 0, 1, 1);
    in_x[0] = 10'd300;
    tick(100, 50, 1, 0);
    tick(300, 50, 1, 0);
    checks++; if (rgb !== 12'hF00) begin failures++; $display("FAIL shadow_old_pos: got %h want F00", rgb); end
    tick(300, 50, 1, 1);
    checks++; if (rgb !== 12'h123) begin failures++; $display("FAIL shadow_no_early: got %h want 123", rgb); end
    tick(100, 50, 1, 0);
    checks++; if (rgb !== 12'hF00) begin failures++; $display("FAIL shadow_fs_pixel: got %h want F00", rgb); end
    tick(0, 0, 0, 0);
    checks++; if (rgb !== 12'h123) begin failures++; $display("FAIL shadow_old_gone: got %h want 123", rgb); end
  endtask

  task automatic test_collision;
    all_off();
    set_spr(0, 200, 100, 10, 10, 1'b1); set_spr(1, 200, 100, 10, 10, 1'b0);
    set_spr(2, 205, 105, 10, 10, 1'b1);
    rom_spr[0] = 12'hF00; rom_spr[1] = 12'h0F0; rom_spr[2] = 12'h00F; rom_spr[3] = 12'hFFF;
    tick(0, 0, 1, 1);
    tick(207, 107, 1, 0);
    tick(0, 0, 1, 1);
    checks++; if (collide !== 3'b010) begin failures++; $display("FAIL coll_set: got %b want 010", collide); end
    tick(300, 300, 1, 0);
    tick(300, 300, 1, 0);
    checks++; if (collide !== 3'b010) begin failures++; $display("FAIL coll_hold: got %b want 010", collide); end
    tick(0, 0, 1, 1);
    checks++; if (collide !== 3'b000) begin failures++; $display("FAIL coll_clear: got %b want 000", collide); end
  endtask

  task automatic test_blank;
    all_off(); set_spr(0, 100, 50, 30, 29, 1'b1); rom_spr[0] = 12'hF00; rom_bg = 12'h123;
    tick(0, 0, 1, 1);
    tick(100, 50, 0, 0);
    tick(10, 20, 1, 0);
    checks++; if (rgb !== 12'h000) begin failures++; $display("FAIL blank_valid: got %h want 000", rgb); end
    tick(10, 370, 1, 0);
    checks++; if (rgb !== 12'h000) begin failures++; $display("FAIL blank_v20: got %h want 000", rgb); end
    tick(10, 369, 1, 0);
    checks++; if (rgb !== 12'h000) begin failures++; $display("FAIL blank_v370: got %h want 000", rgb); end
    tick(10, 30, 1, 0);
    checks++; if (rgb !== 12'h123) begin failures++; $display("FAIL band_v369: got %h want 123", rgb); end
    tick(0, 0, 0, 0);
    checks++; if (rgb !== 12'h123) begin failures++; $display("FAIL band_v30: got %h want 123", rgb); end
  endtask

  task automatic test_random;
    bit fs;
    int h, v;
    for (int n = 0; n < 800; n++) begin
      fs = ($urandom_range(0, 39) == 0);
      if (fs) begin
        for (int k = 0; k < NSPR; k++)
          set_spr(k, $urandom_range(0, 160), $urandom_range(0, 160),
                  $urandom_range(0, 80), $urandom_range(0, 80), 1'($urandom_range(0, 3) != 0));
        for (int i = 0; i < DOTS; i++) begin
          dot_map[i] = 1'($urandom_range(0, 1)); big_map[i] = 1'($urandom_range(0, 1));
        end
      end else if ($urandom_range(0, 9) == 0) begin
        in_x[$urandom_range(0, NSPR-1)] = 10'($urandom_range(0, 200));
      end
      for (int k = 0; k < NSPR; k++)
        rom_spr[k] = ($urandom_range(0, 3) == 0) ? TKEY : 12'($urandom);
      rom_dot = 12'($urandom); rom_big = 12'($urandom); rom_bg = 12'($urandom);
      if ($urandom_range(0, 1) != 0) begin h = $urandom_range(0, 220); v = $urandom_range(0, 220); end
      else begin h = $urandom_range(0, 639); v = $urandom_range(0, 479); end
      tick(h, v, $urandom_range(0, 9) != 0, fs);
      checks++; if (rgb !== exp_rgb)
        begin failures++; $display("FAIL rand_rgb n=%0d: got %h want %h", n, rgb, exp_rgb); end
      checks++; if (collide !== exp_col)
        begin failures++; $display("FAIL rand_collide n=%0d: got %b want %b", n, collide, exp_col); end
      checks++; if (frame_cnt !== 8'(exp_fc))
        begin failures++; $display("FAIL rand_fcnt n=%0d: got %0d want %0d", n, frame_cnt, exp_fc); end
    end
  endtask

  task automatic test_frame_cnt;
    do_reset();
    all_off();
    tick(0, 0, 0, 1);
    checks++; if (frame_cnt !== 8'd1) begin failures++; $display("FAIL fcnt_one: got %0d want 1", frame_cnt); end
    repeat (255) tick(0, 0, 0, 1);
    checks++; if (frame_cnt !== 8'd0) begin failures++; $display("FAIL fcnt_wrap: got %0d want 0", frame_cnt); end
  endtask

  task automatic test_async_reset;
    all_off(); set_spr(0, 100, 50, 30, 29, 1'b1); rom_bg = 12'h123;
    tick(0, 0, 1, 1);
    tick(100, 50, 1, 0);
    rom_spr[0] = 12'hF00;
    tick(110, 50, 1, 0);
    checks++; if (rgb !== 12'hF00) begin failures++; $display("FAIL arst_pre: got %h want F00", rgb); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (rgb !== 12'h000) begin failures++; $display("FAIL arst_rgb: got %h want 000", rgb); end
    checks++; if (frame_cnt !== 8'd0) begin failures++; $display("FAIL arst_fcnt: got %0d want 0", frame_cnt); end
    valid = 1'b0; frame_start = 1'b0; model_reset();
    @(negedge clk); rst_n = 1'b1;
    tick(100, 50, 1, 0);
    checks++; if (rgb !== 12'h000) begin failures++; $display("FAIL arst_black: got %h want 000", rgb); end
    tick(0, 0, 0, 0);
    checks++; if (rgb !== 12'h123) begin failures++; $display("FAIL arst_no_sprite: got %h want 123", rgb); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_dots();
    test_shadow();
    test_collision();
    test_blank();
    test_random();
    test_frame_cnt();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
